// File: rtl/sa_autosa_sdp_wdma_arb_pkg.sv
// Shared types and defaults for the SDP write-DMA arbiter.
package sa_autosa_sdp_wdma_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    typedef logic req_id_t;

    localparam int PW_DEF        = 258;
    localparam int TAG_DEPTH_DEF = 8;

endpackage

// File: rtl/sa_autosa_sdp_wdma_arb_tagfifo.sv
// In-order completion-tag FIFO holding requester IDs; head is visible combinationally.
// Push is ignored when full and pop is ignored when empty, so callers gate both.
module sa_autosa_sdp_wdma_arb_tagfifo
    import sa_autosa_sdp_wdma_arb_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEF
) (
    input  logic       autosa_core_clk,
    input  logic       autosa_core_rstn,
    input  logic       push,
    input  req_id_t    push_id,
    input  logic       pop,
    output req_id_t    head_id,
    output logic [4:0] count,
    output logic       empty,
    output logic       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    req_id_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == 5'd0);
    assign full    = (count == 5'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_id = mem[rd_ptr];

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 1'b0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {4'd0, do_push} - {4'd0, do_pop};
        end
    end

endmodule

// File: rtl/sa_autosa_sdp_wdma_arb.sv
// Two-requester packet arbiter onto one DMA write port; zero-latency forwarding, completions one cycle after dma pulse.
// Packets lock the port until last; ack packets are held off while the tag FIFO is full.
module sa_autosa_sdp_wdma_arb
    import sa_autosa_sdp_wdma_arb_pkg::*;
#(
    parameter int PW        = PW_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic          autosa_core_clk,
    input  logic          autosa_core_rstn,

    input  logic          r0_req_vld,
    output logic          r0_req_rdy,
    input  logic [PW-1:0] r0_req_pd,
    input  logic          r0_req_last,
    input  logic          r0_req_ack,
    output logic          r0_rsp_complete,

    input  logic          r1_req_vld,
    output logic          r1_req_rdy,
    input  logic [PW-1:0] r1_req_pd,
    input  logic          r1_req_last,
    input  logic          r1_req_ack,
    output logic          r1_rsp_complete,

    output logic          dma_wr_req_vld,
    input  logic          dma_wr_req_rdy,
    output logic [PW-1:0] dma_wr_req_pd,
    input  logic          dma_wr_rsp_complete,

    output logic [4:0]    outstanding,
    output logic          err_underflow
);

    state_t  state;
    req_id_t own;
    req_id_t rr_last;

    logic    elig0;
    logic    elig1;
    req_id_t sel;
    logic    fwd;
    logic    sel_last;
    logic    sel_ack;
    logic    accept;
    logic    tag_push;
    logic    tag_pop;
    req_id_t tag_head;
    logic    tag_empty;
    logic    tag_full;

    // Ack packets are only eligible when a tag slot is free right now;
    // a pop in the same cycle does not count.
    always_comb begin
        elig0 = r0_req_vld & (~r0_req_ack | ~tag_full);
        elig1 = r1_req_vld & (~r1_req_ack | ~tag_full);
        sel   = 1'b0;
        fwd   = 1'b0;
        if (state == LOCK) begin
            sel = own;
            fwd = own ? r1_req_vld : r0_req_vld;
        end else begin
            fwd = elig0 | elig1;
            if (elig0 & elig1) begin
                sel = ~rr_last;
            end else begin
                sel = elig1;
            end
        end
    end

    assign dma_wr_req_vld = autosa_core_rstn & fwd;
    assign dma_wr_req_pd  = sel ? r1_req_pd : r0_req_pd;
    assign r0_req_rdy     = autosa_core_rstn & fwd & ~sel & dma_wr_req_rdy;
    assign r1_req_rdy     = autosa_core_rstn & fwd & sel & dma_wr_req_rdy;

    assign sel_last = sel ? r1_req_last : r0_req_last;
    assign sel_ack  = sel ? r1_req_ack : r0_req_ack;
    assign accept   = dma_wr_req_vld & dma_wr_req_rdy;
    assign tag_push = accept & (state == IDLE) & sel_ack;
    assign tag_pop  = dma_wr_rsp_complete & ~tag_empty;

    sa_autosa_sdp_wdma_arb_tagfifo #(
        .DEPTH(TAG_DEPTH)
    ) u_tagfifo (
        .autosa_core_clk (autosa_core_clk),
        .autosa_core_rstn(autosa_core_rstn),
        .push            (tag_push),
        .push_id         (sel),
        .pop             (tag_pop),
        .head_id         (tag_head),
        .count           (outstanding),
        .empty           (tag_empty),
        .full            (tag_full)
    );

    // rr_last resets to r1 so that r0 wins the first contested grant.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            state           <= IDLE;
            own             <= 1'b0;
            rr_last         <= 1'b1;
            r0_rsp_complete <= 1'b0;
            r1_rsp_complete <= 1'b0;
            err_underflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (sel_last) begin
                            rr_last <= sel;
                        end else begin
                            state <= LOCK;
                            own   <= sel;
                        end
                    end
                end
                LOCK: begin
                    if (accept && sel_last) begin
                        state   <= IDLE;
                        rr_last <= own;
                    end
                end
                default: state <= IDLE;
            endcase
            r0_rsp_complete <= tag_pop & ~tag_head;
            r1_rsp_complete <= tag_pop & tag_head;
            if (dma_wr_rsp_complete && tag_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sa_autosa_sdp_wdma_arb.sv
// Directed bench for the write-DMA arbiter: inputs change 1ns after posedge, outputs checked on negedge.
module tb_sa_autosa_sdp_wdma_arb;

    localparam int PW = 258;

    logic          autosa_core_clk;
    logic          autosa_core_rstn;
    logic          r0_req_vld, r0_req_rdy, r0_req_last, r0_req_ack, r0_rsp_complete;
    logic          r1_req_vld, r1_req_rdy, r1_req_last, r1_req_ack, r1_rsp_complete;
    logic [PW-1:0] r0_req_pd, r1_req_pd, dma_wr_req_pd;
    logic          dma_wr_req_vld, dma_wr_req_rdy, dma_wr_rsp_complete;
    logic [4:0]    outstanding;
    logic          err_underflow;

    int checks;
    int errors;

    sa_autosa_sdp_wdma_arb #(.PW(PW), .TAG_DEPTH(8)) dut (
        .autosa_core_clk    (autosa_core_clk),
        .autosa_core_rstn   (autosa_core_rstn),
        .r0_req_vld         (r0_req_vld),
        .r0_req_rdy         (r0_req_rdy),
        .r0_req_pd          (r0_req_pd),
        .r0_req_last        (r0_req_last),
        .r0_req_ack         (r0_req_ack),
        .r0_rsp_complete    (r0_rsp_complete),
        .r1_req_vld         (r1_req_vld),
        .r1_req_rdy         (r1_req_rdy),
        .r1_req_pd          (r1_req_pd),
        .r1_req_last        (r1_req_last),
        .r1_req_ack         (r1_req_ack),
        .r1_rsp_complete    (r1_rsp_complete),
        .dma_wr_req_vld     (dma_wr_req_vld),
        .dma_wr_req_rdy     (dma_wr_req_rdy),
        .dma_wr_req_pd      (dma_wr_req_pd),
        .dma_wr_rsp_complete(dma_wr_rsp_complete),
        .outstanding        (outstanding),
        .err_underflow      (err_underflow)
    );

    initial autosa_core_clk = 1'b0;
    always #5 autosa_core_clk = ~autosa_core_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge autosa_core_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge autosa_core_clk);
    endtask

    function automatic logic [31:0] pd16(input logic [PW-1:0] pd);
        return {16'd0, pd[15:0]};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        autosa_core_rstn    = 1'b0;
        r0_req_vld = 1'b1; r0_req_last = 1'b1; r0_req_ack = 1'b0; r0_req_pd = PW'(32'hA0);
        r1_req_vld = 1'b0; r1_req_last = 1'b1; r1_req_ack = 1'b0; r1_req_pd = PW'(32'hB1);
        dma_wr_req_rdy      = 1'b1;
        dma_wr_rsp_complete = 1'b0;

        // Reset state, with r0 already requesting
        smp();
        chk("rst_dma_vld", 32'(dma_wr_req_vld), 0);
        chk("rst_r0_rdy", 32'(r0_req_rdy), 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_err", 32'(err_underflow), 0);
        chk("rst_rsp", 32'({r1_rsp_complete, r0_rsp_complete}), 0);
        cyc();
        r0_req_vld = 1'b0;
        autosa_core_rstn = 1'b1;

        // Round-robin alternation on single-beat packets
        r0_req_vld = 1'b1; r1_req_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("rr_pd", pd16(dma_wr_req_pd), (i % 2 == 0) ? 32'hA0 : 32'hB1);
            chk("rr_rdy", 32'({r1_req_rdy, r0_req_rdy}), (i % 2 == 0) ? 32'd1 : 32'd2);
            cyc();
        end
        r0_req_vld = 1'b0; r1_req_vld = 1'b0;

        // 4-beat r0 packet with r1 arriving mid-packet and an r0 stall
        r0_req_vld = 1'b1; r0_req_last = 1'b0; r0_req_pd = PW'(32'h1);
        smp(); chk("lock_b1", pd16(dma_wr_req_pd), 32'h1);
        cyc();
        r0_req_pd = PW'(32'h2); r1_req_vld = 1'b1;
        smp(); chk("lock_b2", pd16(dma_wr_req_pd), 32'h2);
        chk("lock_r1_rdy", 32'(r1_req_rdy), 0);
        cyc();
        r0_req_vld = 1'b0;
        smp(); chk("stall_vld", 32'(dma_wr_req_vld), 0);
        chk("stall_r1_rdy", 32'(r1_req_rdy), 0);
        cyc();
        r0_req_vld = 1'b1; r0_req_pd = PW'(32'h3);
        smp(); chk("lock_b3", pd16(dma_wr_req_pd), 32'h3);
        cyc();
        r0_req_pd = PW'(32'h4); r0_req_last = 1'b1;
        smp(); chk("lock_b4", pd16(dma_wr_req_pd), 32'h4);
        cyc();
        r0_req_vld = 1'b0; r0_req_pd = PW'(32'hA0);
        smp(); chk("after_lock_pd", pd16(dma_wr_req_pd), 32'hB1);
        chk("after_lock_r1_rdy", 32'(r1_req_rdy), 1);
        cyc();
        r1_req_vld = 1'b0;

        // Fill tag FIFO from r1
        r1_req_vld = 1'b1; r1_req_ack = 1'b1;
        repeat (8) cyc();
        smp(); chk("full_outstanding", 32'(outstanding), 8);
        chk("full_blocked_vld", 32'(dma_wr_req_vld), 0);
        chk("full_blocked_rdy", 32'(r1_req_rdy), 0);
        cyc();
        r0_req_vld = 1'b1;
        smp(); chk("full_r0_pd", pd16(dma_wr_req_pd), 32'hA0);
        chk("full_r0_rdy", 32'(r0_req_rdy), 1);
        cyc();
        r0_req_vld = 1'b0;
        smp(); chk("full_still8", 32'(outstanding), 8);

        // Completion and blocked ack request in the same cycle
        cyc();
        dma_wr_rsp_complete = 1'b1;
        smp(); chk("same_cyc_blocked", 32'(r1_req_rdy), 0);
        cyc();
        dma_wr_rsp_complete = 1'b0;
        smp(); chk("next_cyc_granted", 32'(r1_req_rdy), 1);
        chk("next_cyc_rsp1", 32'(r1_rsp_complete), 1);
        chk("next_cyc_outstanding", 32'(outstanding), 7);
        cyc();
        r1_req_vld = 1'b0; r1_req_ack = 1'b0;
        smp(); chk("refill_outstanding", 32'(outstanding), 8);
        chk("rsp_one_cycle", 32'(r1_rsp_complete), 0);

        // Drain
        cyc();
        dma_wr_rsp_complete = 1'b1;
        repeat (8) cyc();
        dma_wr_rsp_complete = 1'b0;
        smp(); chk("drain_outstanding", 32'(outstanding), 0);
        chk("drain_err", 32'(err_underflow), 0);

        // Tags r0, r1, r1 and their completions
        cyc();
        r0_req_vld = 1'b1; r0_req_ack = 1'b1;
        cyc();
        r0_req_vld = 1'b0; r0_req_ack = 1'b0;
        r1_req_vld = 1'b1; r1_req_ack = 1'b1;
        cyc(); cyc();
        r1_req_vld = 1'b0; r1_req_ack = 1'b0;
        smp(); chk("tags3_outstanding", 32'(outstanding), 3);
        for (int i = 0; i < 3; i++) begin
            cyc();
            dma_wr_rsp_complete = 1'b1;
            cyc();
            dma_wr_rsp_complete = 1'b0;
            smp();
            chk("tag_rsp", 32'({r1_rsp_complete, r0_rsp_complete}), (i == 0) ? 32'd1 : 32'd2);
            cyc();
            smp();
            chk("tag_rsp_gone", 32'({r1_rsp_complete, r0_rsp_complete}), 0);
        end
        chk("tags_drained", 32'(outstanding), 0);

        // Underflow is sticky and produces no completion
        cyc();
        dma_wr_rsp_complete = 1'b1;
        cyc();
        dma_wr_rsp_complete = 1'b0;
        smp(); chk("uf_err", 32'(err_underflow), 1);
        chk("uf_no_rsp", 32'({r1_rsp_complete, r0_rsp_complete}), 0);
        cyc(); cyc();
        smp(); chk("uf_sticky", 32'(err_underflow), 1);

        // Reset in the middle of a locked packet with a pending tag
        cyc();
        r0_req_vld = 1'b1; r0_req_ack = 1'b1; r0_req_last = 1'b0;
        cyc();
        r0_req_ack = 1'b0;
        r1_req_vld = 1'b1;
        smp(); chk("midlock_outstanding", 32'(outstanding), 1);
        chk("midlock_r1_rdy", 32'(r1_req_rdy), 0);
        cyc();
        autosa_core_rstn = 1'b0;
        smp(); chk("rstlock_dma_vld", 32'(dma_wr_req_vld), 0);
        chk("rstlock_rdy", 32'({r1_req_rdy, r0_req_rdy}), 0);
        chk("rstlock_outstanding", 32'(outstanding), 0);
        chk("rstlock_err", 32'(err_underflow), 0);
        cyc();
        autosa_core_rstn = 1'b1;
        r0_req_vld = 1'b0; r0_req_last = 1'b1;
        smp(); chk("postrst_pd", pd16(dma_wr_req_pd), 32'hB1);
        chk("postrst_r1_rdy", 32'(r1_req_rdy), 1);
        cyc();
        r1_req_vld = 1'b0;
        dma_wr_rsp_complete = 1'b1;
        cyc();
        dma_wr_rsp_complete = 1'b0;
        smp(); chk("postrst_no_rsp", 32'({r1_rsp_complete, r0_rsp_complete}), 0);
        chk("postrst_uf", 32'(err_underflow), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
